// File: rtl/serial_tx_arbiter_if.sv
// Purpose: groups the requester, transmitter and status signals of serial_tx_arbiter.
// Latency: none, wiring only.
// Backpressure: requests are level signals held until the matching ack pulse.
// Ports: CPU and DMA request/data/TB8, transmitter TI in; acks, dones, SBUF/TB8/start,
//        TI clear, busy/owner/timeout status out.
interface serial_tx_arbiter_if;
  logic       serial_cpu_req_i;
  logic [7:0] serial_cpu_data_i;
  logic       serial_cpu_tb8_i;
  logic       serial_dma_req_i;
  logic [7:0] serial_dma_data_i;
  logic       serial_dma_tb8_i;
  logic       serial_ti_i;
  logic       serial_cpu_ack_o;
  logic       serial_cpu_done_o;
  logic       serial_dma_ack_o;
  logic       serial_dma_done_o;
  logic [7:0] serial_data_sbuf_o;
  logic       serial_scon3_tb8_o;
  logic       serial_serial_tx_o;
  logic       serial_ti_clr_o;
  logic       serial_busy_o;
  logic       serial_owner_o;
  logic       serial_timeout_o;

  // Arbiter side.
  modport slave (
    input  serial_cpu_req_i, serial_cpu_data_i, serial_cpu_tb8_i,
    input  serial_dma_req_i, serial_dma_data_i, serial_dma_tb8_i,
    input  serial_ti_i,
    output serial_cpu_ack_o, serial_cpu_done_o, serial_dma_ack_o, serial_dma_done_o,
    output serial_data_sbuf_o, serial_scon3_tb8_o, serial_serial_tx_o, serial_ti_clr_o,
    output serial_busy_o, serial_owner_o, serial_timeout_o
  );

  // Requester / transmitter side.
  modport master (
    output serial_cpu_req_i, serial_cpu_data_i, serial_cpu_tb8_i,
    output serial_dma_req_i, serial_dma_data_i, serial_dma_tb8_i,
    output serial_ti_i,
    input  serial_cpu_ack_o, serial_cpu_done_o, serial_dma_ack_o, serial_dma_done_o,
    input  serial_data_sbuf_o, serial_scon3_tb8_o, serial_serial_tx_o, serial_ti_clr_o,
    input  serial_busy_o, serial_owner_o, serial_timeout_o
  );
endinterface

// File: rtl/serial_tx_arbiter.sv
// Purpose: round-robin share of one serial transmitter between CPU SBUF writes and the log DMA.
// Latency: ack 1 cycle after request, start 2 cycles after ack, done 1 cycle after TI.
// Backpressure: requests held until ack; stale TI stalls in CLEAR; watchdog aborts stuck frames.
// Ports: serial_clock_i/serial_reset_i (async, active high), bus = serial_tx_arbiter_if.slave.
module serial_tx_arbiter #(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic               serial_clock_i,
  input  logic               serial_reset_i,
  serial_tx_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_CLEAR, S_START, S_BUSY, S_DONE
  } state_t;

  localparam logic [15:0] CNT_LIMIT = TIMEOUT - 16'd1;

  state_t      r_state;
  logic [7:0]  r_sbuf;
  logic        r_tb8;
  logic        r_owner;
  logic        r_last_served;
  logic        r_timeout;
  logic [15:0] r_cnt;
  logic        r_cpu_ack;
  logic        r_dma_ack;
  logic        r_cpu_done;
  logic        r_dma_done;
  logic        r_tx;
  logic        r_ti_clr;

  // DMA wins when it is alone, or when both request and the CPU went last.
  logic w_pick_dma;
  assign w_pick_dma = bus.serial_dma_req_i &
                      (~bus.serial_cpu_req_i | ~r_last_served);

  always_ff @(posedge serial_clock_i or posedge serial_reset_i) begin
    if (serial_reset_i) begin
      r_state       <= S_IDLE;
      r_sbuf        <= 8'h00;
      r_tb8         <= 1'b0;
      r_owner       <= 1'b0;
      r_last_served <= 1'b1;
      r_timeout     <= 1'b0;
      r_cnt         <= 16'd0;
      r_cpu_ack     <= 1'b0;
      r_dma_ack     <= 1'b0;
      r_cpu_done    <= 1'b0;
      r_dma_done    <= 1'b0;
      r_tx          <= 1'b0;
      r_ti_clr      <= 1'b0;
    end else begin
      // Pulse outputs are set only on the edge entering their state.
      r_cpu_ack  <= 1'b0;
      r_dma_ack  <= 1'b0;
      r_cpu_done <= 1'b0;
      r_dma_done <= 1'b0;
      r_tx       <= 1'b0;
      r_ti_clr   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.serial_cpu_req_i || bus.serial_dma_req_i) begin
            r_sbuf    <= w_pick_dma ? bus.serial_dma_data_i : bus.serial_cpu_data_i;
            r_tb8     <= w_pick_dma ? bus.serial_dma_tb8_i  : bus.serial_cpu_tb8_i;
            r_owner   <= w_pick_dma;
            r_timeout <= 1'b0;
            r_cpu_ack <= ~w_pick_dma;
            r_dma_ack <= w_pick_dma;
            r_state   <= S_GRANT;
          end
        end
        S_GRANT: r_state <= S_CLEAR;
        S_CLEAR: begin
          // Hold the clear request while a stale TI from a previous frame is up.
          if (bus.serial_ti_i) begin
            r_ti_clr <= 1'b1;
          end else begin
            r_tx    <= 1'b1;
            r_cnt   <= 16'd0;
            r_state <= S_START;
          end
        end
        S_START: begin
          r_cnt   <= r_cnt + 16'd1;
          r_state <= S_BUSY;
        end
        S_BUSY: begin
          // TI is checked first so a completion on the limit cycle is not a timeout.
          if (bus.serial_ti_i || (r_cnt == CNT_LIMIT)) begin
            r_timeout  <= ~bus.serial_ti_i;
            r_cpu_done <= ~r_owner;
            r_dma_done <= r_owner;
            r_ti_clr   <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_DONE: begin
          r_last_served <= r_owner;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.serial_cpu_ack_o   = r_cpu_ack;
  assign bus.serial_dma_ack_o   = r_dma_ack;
  assign bus.serial_cpu_done_o  = r_cpu_done;
  assign bus.serial_dma_done_o  = r_dma_done;
  assign bus.serial_data_sbuf_o = r_sbuf;
  assign bus.serial_scon3_tb8_o = r_tb8;
  assign bus.serial_serial_tx_o = r_tx;
  assign bus.serial_ti_clr_o    = r_ti_clr;
  assign bus.serial_busy_o      = (r_state != S_IDLE);
  assign bus.serial_owner_o     = r_owner;
  assign bus.serial_timeout_o   = r_timeout;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Purpose: self-checking bench for serial_tx_arbiter (default and short watchdog instances).
// Latency: checks ack/start/done cycle offsets against bench-side expectations.
// Backpressure: drives level requests, TI returns, stale TI and resets mid-frame.
module tb_serial_tx_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_tx_arbiter_if bus ();
  serial_tx_arbiter_if wd ();

  serial_tx_arbiter u_dut (
    .serial_clock_i(clk),
    .serial_reset_i(rst),
    .bus           (bus)
  );

  serial_tx_arbiter #(.TIMEOUT(16'd10)) u_dut_wd (
    .serial_clock_i(clk),
    .serial_reset_i(rst),
    .bus           (wd)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // kind: 0 ack, 1 start, 2 done. refsel: 0 request, 1 ack, 2 start, 3 TI raise.
  typedef struct {
    int         kind;
    bit         owner;
    logic [7:0] data;
    bit         tb8;
    int         lat;
    int         refsel;
    bit         tmo;
  } exp_t;
  exp_t sbq[$];

  int req_cyc = 0, ack_cyc = 0, start_cyc = 0, ti_cyc = 0;
  int n_ack = 0, n_start = 0, n_done = 0, n_clr = 0;

  task automatic push(input int kind, input bit owner, input logic [7:0] data, input bit tb8,
                      input int lat, input int refsel, input bit tmo);
    exp_t e;
    e.kind = kind; e.owner = owner; e.data = data; e.tb8 = tb8;
    e.lat = lat; e.refsel = refsel; e.tmo = tmo;
    sbq.push_back(e);
  endtask

  task automatic observe(input int kind, input bit who);
    exp_t e;
    int   rc;
    if (sbq.size() == 0) begin
      check_val($sformatf("sb_pending_kind%0d", kind), sbq.size(), 1);
    end else begin
      e = sbq.pop_front();
      check_val("evt_kind", kind, e.kind);
      check_val("evt_owner", who, e.owner);
      rc = (e.refsel == 0) ? req_cyc : (e.refsel == 1) ? ack_cyc :
           (e.refsel == 2) ? start_cyc : ti_cyc;
      if (e.lat >= 0) check_val($sformatf("evt%0d_latency", kind), cyc - rc, e.lat);
      case (kind)
        0: begin
          check_val("ack_sbuf", bus.serial_data_sbuf_o, e.data);
          check_val("ack_tb8", bus.serial_scon3_tb8_o, e.tb8);
          check_val("ack_timeout_clear", bus.serial_timeout_o, 0);
          check_val("ack_busy", bus.serial_busy_o, 1);
          ack_cyc = cyc;
          n_ack++;
        end
        1: begin
          start_cyc = cyc;
          n_start++;
        end
        default: begin
          check_val("done_ti_clr", bus.serial_ti_clr_o, 1);
          check_val("done_timeout", bus.serial_timeout_o, e.tmo);
          n_done++;
        end
      endcase
    end
  endtask

  // Scoreboard monitor: outputs sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.serial_cpu_ack_o || bus.serial_dma_ack_o) observe(0, bus.serial_dma_ack_o);
      if (bus.serial_serial_tx_o) observe(1, bus.serial_owner_o);
      if (bus.serial_cpu_done_o || bus.serial_dma_done_o) observe(2, bus.serial_dma_done_o);
      if (bus.serial_ti_clr_o && !bus.serial_cpu_done_o && !bus.serial_dma_done_o) n_clr++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int cnt_of(input int kind);
    return (kind == 0) ? n_ack : (kind == 1) ? n_start : n_done;
  endfunction

  task automatic wait_event(input int kind, input int prev);
    int i = 0;
    while (cnt_of(kind) <= prev && i < 400) begin
      @(negedge clk);
      #1;
      i++;
    end
    if (cnt_of(kind) <= prev) check_val($sformatf("wait_evt%0d", kind), cnt_of(kind), prev + 1);
  endtask

  task automatic ti_pulse(input int delay);
    repeat (delay) @(posedge clk);
    #1;
    bus.serial_ti_i = 1'b1;
    ti_cyc = cyc;
    @(posedge clk);
    #1;
    bus.serial_ti_i = 1'b0;
  endtask

  function automatic logic [17:0] outs(input bit sel_wd);
    if (sel_wd)
      return {wd.serial_cpu_ack_o, wd.serial_cpu_done_o, wd.serial_dma_ack_o, wd.serial_dma_done_o,
              wd.serial_data_sbuf_o, wd.serial_scon3_tb8_o, wd.serial_serial_tx_o,
              wd.serial_ti_clr_o, wd.serial_busy_o, wd.serial_owner_o, wd.serial_timeout_o};
    return {bus.serial_cpu_ack_o, bus.serial_cpu_done_o, bus.serial_dma_ack_o, bus.serial_dma_done_o,
            bus.serial_data_sbuf_o, bus.serial_scon3_tb8_o, bus.serial_serial_tx_o,
            bus.serial_ti_clr_o, bus.serial_busy_o, bus.serial_owner_o, bus.serial_timeout_o};
  endfunction

  // One frame from a single requester; request dropped after its ack.
  task automatic single_frame(input bit who, input logic [7:0] d, input bit t, input int ti_delay);
    int a, s, dn;
    a = n_ack; s = n_start; dn = n_done;
    push(0, who, d, t, 1, 0, 0);
    push(1, who, 8'h00, 1'b0, 2, 1, 0);
    tick();
    if (who) begin
      bus.serial_dma_req_i = 1'b1; bus.serial_dma_data_i = d; bus.serial_dma_tb8_i = t;
    end else begin
      bus.serial_cpu_req_i = 1'b1; bus.serial_cpu_data_i = d; bus.serial_cpu_tb8_i = t;
    end
    req_cyc = cyc;
    wait_event(0, a);
    bus.serial_cpu_req_i = 1'b0;
    bus.serial_dma_req_i = 1'b0;
    wait_event(1, s);
    push(2, who, 8'h00, 1'b0, 1, 3, 0);
    ti_pulse(ti_delay);
    wait_event(2, dn);
  endtask

  // Short-watchdog instance: directed frame with TI either absent or on the limit cycle.
  task automatic wd_wait(input int sel, output int seen_cyc);
    int i = 0;
    logic hit = 1'b0;
    seen_cyc = -1;
    while (!hit && i < 100) begin
      @(negedge clk);
      #1;
      hit = (sel == 0) ? wd.serial_cpu_ack_o : (sel == 1) ? wd.serial_serial_tx_o : wd.serial_cpu_done_o;
      i++;
    end
    if (hit) seen_cyc = cyc - 1;
    else check_val($sformatf("wd_wait%0d", sel), hit, 1);
  endtask

  task automatic wd_frame(input bit ti_at_limit, input bit exp_tmo);
    int ca, cs, cd;
    tick();
    wd.serial_cpu_req_i = 1'b1;
    wd.serial_cpu_data_i = 8'h77;
    wd_wait(0, ca);
    check_val("wd_ack_timeout_cleared", wd.serial_timeout_o, 0);
    wd.serial_cpu_req_i = 1'b0;
    wd_wait(1, cs);
    if (ti_at_limit) begin
      repeat (9) @(posedge clk);
      #1;
      wd.serial_ti_i = 1'b1;
      @(posedge clk);
      #1;
      wd.serial_ti_i = 1'b0;
    end
    wd_wait(2, cd);
    check_val("wd_done_after_start", cd - cs, 10);
    check_val("wd_timeout_flag", wd.serial_timeout_o, exp_tmo);
    check_val("wd_done_ti_clr", wd.serial_ti_clr_o, 1);
    repeat (3) tick();
    check_val("wd_timeout_sticky", wd.serial_timeout_o, exp_tmo);
    check_val("wd_idle", wd.serial_busy_o, 0);
  endtask

  initial begin
    int a, s, dn, c0;
    bus.serial_cpu_req_i = 0; bus.serial_cpu_data_i = 0; bus.serial_cpu_tb8_i = 0;
    bus.serial_dma_req_i = 0; bus.serial_dma_data_i = 0; bus.serial_dma_tb8_i = 0;
    bus.serial_ti_i = 0;
    wd.serial_cpu_req_i = 0; wd.serial_cpu_data_i = 0; wd.serial_cpu_tb8_i = 0;
    wd.serial_dma_req_i = 0; wd.serial_dma_data_i = 0; wd.serial_dma_tb8_i = 0;
    wd.serial_ti_i = 0;

    // Reset state.
    repeat (3) tick();
    check_val("reset_outputs", outs(0), 0);
    check_val("reset_outputs_wd", outs(1), 0);
    rst = 1'b0;

    // Single CPU frame, TI returned 20 cycles after start.
    single_frame(1'b0, 8'hA5, 1'b1, 20);
    tick();
    check_val("sbuf_held_idle", bus.serial_data_sbuf_o, 8'hA5);
    check_val("tb8_held_idle", bus.serial_scon3_tb8_o, 1);
    check_val("busy_idle", bus.serial_busy_o, 0);

    // Both requesting from reset: CPU, DMA, CPU, DMA.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push(0, 1'b0, 8'h3C, 1'b0, 1, 0, 0);
    push(1, 1'b0, 8'h00, 1'b0, 2, 1, 0);
    a = n_ack;
    tick();
    bus.serial_cpu_req_i = 1'b1; bus.serial_cpu_data_i = 8'h3C; bus.serial_cpu_tb8_i = 1'b0;
    bus.serial_dma_req_i = 1'b1; bus.serial_dma_data_i = 8'hC3; bus.serial_dma_tb8_i = 1'b1;
    req_cyc = cyc;
    for (int i = 0; i < 4; i++) begin
      wait_event(0, a);
      if (i == 3) begin
        bus.serial_cpu_req_i = 1'b0;
        bus.serial_dma_req_i = 1'b0;
      end
      s = n_start;
      wait_event(1, s - 1 + ((n_start > s) ? 0 : 1));
      push(2, i[0], 8'h00, 1'b0, 1, 3, 0);
      if (i < 3) begin
        push(0, ~i[0], i[0] ? 8'h3C : 8'hC3, ~i[0], 3, 3, 0);
        push(1, ~i[0], 8'h00, 1'b0, 2, 1, 0);
      end
      a = n_ack; dn = n_done;
      ti_pulse(10);
      wait_event(2, dn);
    end

    // Stale TI: DMA request while TI is high for 5 CLEAR cycles.
    c0 = n_clr;
    a = n_ack; s = n_start;
    push(0, 1'b1, 8'h5A, 1'b0, 1, 0, 0);
    push(1, 1'b1, 8'h00, 1'b0, 7, 1, 0);
    tick();
    bus.serial_ti_i = 1'b1;
    bus.serial_dma_req_i = 1'b1; bus.serial_dma_data_i = 8'h5A; bus.serial_dma_tb8_i = 1'b0;
    req_cyc = cyc;
    wait_event(0, a);
    bus.serial_dma_req_i = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    bus.serial_ti_i = 1'b0;
    wait_event(1, s);
    check_val("stale_clr_cycles", n_clr - c0, 5);
    dn = n_done;
    push(2, 1'b1, 8'h00, 1'b0, 1, 3, 0);
    ti_pulse(5);
    wait_event(2, dn);

    // Reset in BUSY. A completed CPU frame first makes last_served = CPU.
    single_frame(1'b0, 8'h11, 1'b0, 4);
    a = n_ack; s = n_start;
    push(0, 1'b1, 8'h22, 1'b1, 1, 0, 0);
    push(1, 1'b1, 8'h00, 1'b0, 2, 1, 0);
    tick();
    bus.serial_dma_req_i = 1'b1; bus.serial_dma_data_i = 8'h22; bus.serial_dma_tb8_i = 1'b1;
    req_cyc = cyc;
    wait_event(0, a);
    wait_event(1, s);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check_val("reset_in_busy_outputs", outs(0), 0);
    bus.serial_cpu_req_i = 1'b1; bus.serial_cpu_data_i = 8'h33; bus.serial_cpu_tb8_i = 1'b0;
    // Tie after reset goes to the CPU.
    a = n_ack; s = n_start;
    push(0, 1'b0, 8'h33, 1'b0, 1, 0, 0);
    push(1, 1'b0, 8'h00, 1'b0, 2, 1, 0);
    tick();
    rst = 1'b0;
    req_cyc = cyc;
    wait_event(0, a);
    bus.serial_cpu_req_i = 1'b0;
    wait_event(1, s);
    push(2, 1'b0, 8'h00, 1'b0, 1, 3, 0);
    push(0, 1'b1, 8'h22, 1'b1, 3, 3, 0);
    push(1, 1'b1, 8'h00, 1'b0, 2, 1, 0);
    a = n_ack; s = n_start; dn = n_done;
    ti_pulse(6);
    wait_event(2, dn);
    wait_event(0, a);
    wait_event(1, s);
    // Reset again in BUSY; only DMA pending afterwards.
    repeat (2) tick();
    rst = 1'b1;
    #1;
    check_val("reset2_in_busy_outputs", outs(0), 0);
    a = n_ack; s = n_start;
    push(0, 1'b1, 8'h22, 1'b1, 1, 0, 0);
    push(1, 1'b1, 8'h00, 1'b0, 2, 1, 0);
    tick();
    rst = 1'b0;
    req_cyc = cyc;
    wait_event(0, a);
    bus.serial_dma_req_i = 1'b0;
    wait_event(1, s);
    dn = n_done;
    push(2, 1'b1, 8'h00, 1'b0, 1, 3, 0);
    ti_pulse(3);
    wait_event(2, dn);

    // Watchdog instance: pure timeout, then TI exactly on the limit cycle.
    wd_frame(1'b0, 1'b1);
    wd_frame(1'b1, 1'b0);

    repeat (4) tick();
    check_val("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
